// File: rtl/i2s_slave.sv
// Slave-side I2S endpoint: deserializes the master's Philips-aligned IQ slots into
// parallel words and serializes a latched TX IQ pair back, all on one fast clock.
module i2s_slave #(
   parameter int RX_WIDTH = 24,
   parameter int TX_WIDTH = 16,
   parameter int SLOT     = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                bclk,
   input  logic                lrclk,
   input  logic                sdata_in,
   output logic                sdata_out,
   input  logic [TX_WIDTH-1:0] tx_real,
   input  logic [TX_WIDTH-1:0] tx_imag,
   output logic                tx_load,
   output logic [RX_WIDTH-1:0] rx_real,
   output logic [RX_WIDTH-1:0] rx_imag,
   output logic                frame_valid,
   output logic                frame_err,
   output logic                locked
);
   localparam int CW = $clog2(SLOT + 2);
   // The counter holds SLOT-1 when a slot of exactly SLOT rise strobes closes.
   localparam logic [CW-1:0] CNT_GOOD  = CW'(SLOT - 1);
   localparam logic [CW-1:0] CNT_STUCK = CW'(SLOT);
   localparam logic [CW-1:0] CNT_SAT   = CW'(SLOT + 1);
   localparam logic [CW-1:0] CNT_RXEND = CW'(RX_WIDTH);

   typedef enum logic {UNSYNC = 1'b0, RUN = 1'b1} state_t;

   logic                bclk_s1_q, bclk_s2_q, bclk_s3_q;
   logic                lr_s1_q, lr_s2_q, sd_s1_q, sd_s2_q;
   state_t              state_q, state_d;
   logic                lr_rx_q, lr_rx_d, lr_tx_q, lr_tx_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [RX_WIDTH-1:0] rx_sh_q, rx_sh_d, left_hold_q, left_hold_d;
   logic                left_ok_q, left_ok_d;
   logic [RX_WIDTH-1:0] rx_real_q, rx_real_d, rx_imag_q, rx_imag_d;
   logic                frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;
   logic [TX_WIDTH-1:0] tx_sh_q, tx_sh_d, tx_im_q, tx_im_d;
   logic                tx_load_q, tx_load_d, sdo_q, sdo_d, locked_q;

   logic rise, fall, rx_chg, tx_chg, left_start;

   assign rise       = bclk_s2_q & ~bclk_s3_q;
   assign fall       = ~bclk_s2_q & bclk_s3_q;
   assign rx_chg     = lr_s2_q ^ lr_rx_q;
   assign tx_chg     = lr_s2_q ^ lr_tx_q;
   assign left_start = rx_chg & ~lr_s2_q;

   always_comb begin
      state_d       = state_q;
      lr_rx_d       = lr_rx_q;
      cnt_d         = cnt_q;
      rx_sh_d       = rx_sh_q;
      left_hold_d   = left_hold_q;
      left_ok_d     = left_ok_q;
      rx_real_d     = rx_real_q;
      rx_imag_d     = rx_imag_q;
      frame_valid_d = 1'b0;
      frame_err_d   = 1'b0;
      lr_tx_d       = lr_tx_q;
      tx_sh_d       = tx_sh_q;
      tx_im_d       = tx_im_q;
      tx_load_d     = 1'b0;
      sdo_d         = sdo_q;

      if (rise) begin
         lr_rx_d = lr_s2_q;
         if (rx_chg) begin
            cnt_d   = '0;
            rx_sh_d = '0;
            if (state_q == UNSYNC) begin
               if (left_start) begin
                  state_d   = RUN;
                  left_ok_d = 1'b0;
               end
            end else if (cnt_q != CNT_GOOD) begin
               // A bad slot kills the frame; a left start re-locks on the same strobe.
               frame_err_d = 1'b1;
               left_ok_d   = 1'b0;
               state_d     = left_start ? RUN : UNSYNC;
            end else if (left_start) begin
               if (left_ok_q) begin
                  frame_valid_d = 1'b1;
                  rx_real_d     = left_hold_q;
                  rx_imag_d     = rx_sh_q;
               end
               left_ok_d = 1'b0;
            end else begin
               left_hold_d = rx_sh_q;
               left_ok_d   = 1'b1;
            end
         end else begin
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
            if (cnt_q < CNT_RXEND) rx_sh_d = {rx_sh_q[RX_WIDTH-2:0], sd_s2_q};
            if (state_q == RUN && cnt_q == CNT_STUCK) begin
               frame_err_d = 1'b1;
               state_d     = UNSYNC;
            end
         end
      end

      if (fall) begin
         lr_tx_d = lr_s2_q;
         if (tx_chg) begin
            sdo_d = 1'b0;
            if (!lr_s2_q) begin
               tx_sh_d   = tx_real;
               tx_im_d   = tx_imag;
               tx_load_d = 1'b1;
            end else begin
               tx_sh_d = tx_im_q;
            end
         end else begin
            // Zero fill makes every index past TX_WIDTH drive 0.
            sdo_d   = tx_sh_q[TX_WIDTH-1];
            tx_sh_d = {tx_sh_q[TX_WIDTH-2:0], 1'b0};
         end
      end

      if (state_d != RUN) sdo_d = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bclk_s1_q     <= 1'b0;
         bclk_s2_q     <= 1'b0;
         bclk_s3_q     <= 1'b0;
         lr_s1_q       <= 1'b0;
         lr_s2_q       <= 1'b0;
         sd_s1_q       <= 1'b0;
         sd_s2_q       <= 1'b0;
         state_q       <= UNSYNC;
         lr_rx_q       <= 1'b0;
         lr_tx_q       <= 1'b0;
         cnt_q         <= '0;
         rx_sh_q       <= '0;
         left_hold_q   <= '0;
         left_ok_q     <= 1'b0;
         rx_real_q     <= '0;
         rx_imag_q     <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         tx_sh_q       <= '0;
         tx_im_q       <= '0;
         tx_load_q     <= 1'b0;
         sdo_q         <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         bclk_s1_q     <= bclk;
         bclk_s2_q     <= bclk_s1_q;
         bclk_s3_q     <= bclk_s2_q;
         lr_s1_q       <= lrclk;
         lr_s2_q       <= lr_s1_q;
         sd_s1_q       <= sdata_in;
         sd_s2_q       <= sd_s1_q;
         state_q       <= state_d;
         lr_rx_q       <= lr_rx_d;
         lr_tx_q       <= lr_tx_d;
         cnt_q         <= cnt_d;
         rx_sh_q       <= rx_sh_d;
         left_hold_q   <= left_hold_d;
         left_ok_q     <= left_ok_d;
         rx_real_q     <= rx_real_d;
         rx_imag_q     <= rx_imag_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         tx_sh_q       <= tx_sh_d;
         tx_im_q       <= tx_im_d;
         tx_load_q     <= tx_load_d;
         sdo_q         <= sdo_d;
         locked_q      <= (state_d == RUN);
      end
   end

   assign sdata_out   = sdo_q;
   assign tx_load     = tx_load_q;
   assign rx_real     = rx_real_q;
   assign rx_imag     = rx_imag_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign locked      = locked_q;
endmodule

// File: tb/tb_i2s_slave.sv
// Bench for i2s_slave: a Philips I2S master model drives frames and reads DIN back,
// and a frame-level reference predicts received pairs, errors and TX words.
`timescale 1ns/1ps
module tb_i2s_slave;
   localparam int  RXW  = 24;
   localparam int  TXW  = 16;
   localparam time HALF = 165;

   logic           clock = 1'b0;
   logic           reset, bclk, lrclk, sdata_in, sdata_out;
   logic [TXW-1:0] tx_real, tx_imag;
   logic           tx_load, frame_valid, frame_err, locked;
   logic [RXW-1:0] rx_real, rx_imag;

   int errors = 0;
   int checks = 0;

   logic [2*RXW-1:0] fv_q[$];
   int               err_seen = 0, load_seen = 0;
   int               exp_err = 0, exp_load = 0;
   logic             pend_rx = 1'b0, pend_tx = 1'b0, carry = 1'b0;
   logic [2*RXW-1:0] pend_pair;
   logic [30:0]      pend_bits;
   logic [31:0]      pend_word;

   always #10 clock = ~clock;

   i2s_slave #(.RX_WIDTH(RXW), .TX_WIDTH(TXW), .SLOT(32)) dut (
      .clock(clock), .reset(reset), .bclk(bclk), .lrclk(lrclk), .sdata_in(sdata_in),
      .sdata_out(sdata_out), .tx_real(tx_real), .tx_imag(tx_imag), .tx_load(tx_load),
      .rx_real(rx_real), .rx_imag(rx_imag), .frame_valid(frame_valid),
      .frame_err(frame_err), .locked(locked)
   );

   always @(negedge clock) begin
      if (frame_valid) fv_q.push_back({rx_real, rx_imag});
      if (frame_err) err_seen++;
      if (tx_load) load_seen++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_real"}, 64'(rx_real), 64'd0);
      check({tag, "_rx_imag"}, 64'(rx_imag), 64'd0);
      check({tag, "_sdata_out"}, 64'(sdata_out), 64'd0);
      check({tag, "_frame_valid"}, 64'(frame_valid), 64'd0);
      check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
      check({tag, "_tx_load"}, 64'(tx_load), 64'd0);
      check({tag, "_locked"}, 64'(locked), 64'd0);
   endtask

   // One BCLK period: master drives on the fall, samples DIN on the rise.
   task automatic bit_cyc(input logic lr, input logic d, output logic s);
      bclk = 1'b0; lrclk = lr; sdata_in = d;
      #HALF;
      bclk = 1'b1; s = sdata_out;
      #HALF;
   endtask

   // One frame: left slot of nl BCLKs, right slot of nr BCLKs, Philips one-bit delay.
   // rst_at >= 0 pulses reset during that left bit; at bit chg_at tx_imag changes in the
   // left slot and tx_real changes in the right slot.
   task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw, input int nl,
                             input int nr, input int rst_at, input int chg_at,
                             input logic [TXW-1:0] new_real, input logic [TXW-1:0] new_imag);
      logic           s;
      logic [31:0]    sh;
      logic [30:0]    lbits, rbits;
      logic [TXW-1:0] lat_r, lat_i;
      int             ones;
      bit             good;
      lat_r = tx_real;
      lat_i = tx_imag;
      exp_load++;
      sh = lw; lbits = '0; rbits = '0; ones = 0;
      for (int i = 0; i < nl; i++) begin
         if (i == chg_at) tx_imag = new_imag;
         if (i == rst_at) begin
            reset = 1'b1; bclk = 1'b0; sdata_in = 1'b0;
            #HALF;
            check_reset_outputs("midreset");
            bclk = 1'b1;
            #HALF;
            reset = 1'b0;
         end else begin
            bit_cyc(1'b0, (i == 0) ? carry : sh[31], s);
         end
         if (i >= 1) sh = sh << 1;
         if (i >= 1 && i <= 31) lbits = {lbits[29:0], s};
         if (i == 0) begin
            check("locked_at_left", 64'(locked), 64'd1);
            if (pend_tx) check("tx_right_word", 64'({pend_bits, s}), 64'(pend_word));
            check("frame_valid_count", 64'(fv_q.size()), 64'(pend_rx));
            if (pend_rx && fv_q.size() > 0) check("rx_pair", 64'(fv_q[0]), 64'(pend_pair));
            fv_q.delete();
            check("frame_err_count", 64'(err_seen), 64'(exp_err));
            check("tx_load_count", 64'(load_seen), 64'(exp_load));
            pend_rx = 1'b0;
            pend_tx = 1'b0;
         end
      end
      good = (nl == 32) && (rst_at < 0);
      sh = rw;
      for (int i = 0; i < nr; i++) begin
         if (i == chg_at) tx_real = new_real;
         bit_cyc(1'b1, (i == 0) ? lw[0] : sh[31], s);
         if (i >= 1) sh = sh << 1;
         if (i >= 1 && i <= 31) rbits = {rbits[29:0], s};
         ones += int'(s);
         if (i == 0) begin
            check("locked_at_right", 64'(locked), 64'(good));
            if (good) check("tx_left_word", 64'({lbits, s}), 64'({lat_r, 16'h0000}));
         end
      end
      if (!good) check("tx_quiet_unsync", 64'(ones), 64'd0);
      carry     = rw[0];
      pend_rx   = good && (nr == 32);
      pend_pair = {lw[31:8], rw[31:8]};
      pend_tx   = good && (nr == 32);
      pend_bits = rbits;
      pend_word = {lat_i, 16'h0000};
      if (rst_at < 0 && (nl != 32 || nr != 32)) exp_err++;
   endtask

   task automatic rand_frame(input int nl, input int nr, input int rst_at);
      tx_real = TXW'($urandom);
      tx_imag = TXW'($urandom);
      send_frame($urandom, $urandom, nl, nr, rst_at, -1, '0, '0);
   endtask

   initial begin
      logic s;
      reset = 1'b1; bclk = 1'b0; lrclk = 1'b1; sdata_in = 1'b0;
      tx_real = '0; tx_imag = '0;
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;

      // Preamble right slot so the first left start is a high-to-low change.
      for (int i = 0; i < 32; i++) bit_cyc(1'b1, 1'b0, s);

      // Fixed RX pattern and fixed TX pair.
      tx_real = 16'h8001; tx_imag = 16'h7FFE;
      for (int k = 0; k < 3; k++)
         send_frame({24'hA5A5A5, 8'h00}, {24'h123456, 8'h00}, 32, 32, -1, -1, '0, '0);

      // Coherent latch: inputs change mid-frame, next frame picks them up.
      tx_real = 16'h1111; tx_imag = 16'h3333;
      send_frame($urandom, $urandom, 32, 32, -1, 10, 16'h2222, 16'h4444);
      send_frame($urandom, $urandom, 32, 32, -1, -1, '0, '0);

      for (int k = 0; k < 4; k++) rand_frame(32, 32, -1);

      // Short right slot: error, same-strobe re-lock, next frame good.
      rand_frame(32, 31, -1);
      rand_frame(32, 32, -1);
      rand_frame(32, 32, -1);

      // Short left slot and stuck lrclk: error, unlocked until the next left start.
      rand_frame(30, 32, -1);
      rand_frame(32, 32, -1);
      rand_frame(40, 32, -1);
      rand_frame(32, 32, -1);
      rand_frame(32, 32, -1);

      // Reset at bit 10 of a left slot; lock again only after a full frame.
      rand_frame(32, 32, 10);
      rand_frame(32, 32, -1);
      rand_frame(32, 32, -1);
      rand_frame(32, 32, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
